// File: rtl/cv32e40p_rf_wb_ctrl.sv
// Register-file write-back arbiter: grants up to two of LSU/APU/EX results per cycle onto
// two registered write ports, with EX anti-starvation, a pending-write scoreboard and forwarding.
module cv32e40p_rf_wb_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int FPU        = 0,
   parameter int ZFINX      = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ex_valid_i,
   input  logic [ADDR_WIDTH-1:0]    ex_addr_i,
   input  logic [DATA_WIDTH-1:0]    ex_data_i,
   output logic                     ex_ready_o,
   input  logic                     lsu_valid_i,
   input  logic [ADDR_WIDTH-1:0]    lsu_addr_i,
   input  logic [DATA_WIDTH-1:0]    lsu_data_i,
   output logic                     lsu_ready_o,
   input  logic                     apu_valid_i,
   input  logic [ADDR_WIDTH-1:0]    apu_addr_i,
   input  logic [DATA_WIDTH-1:0]    apu_data_i,
   output logic                     apu_ready_o,
   output logic [ADDR_WIDTH-1:0]    waddr_a_o,
   output logic [DATA_WIDTH-1:0]    wdata_a_o,
   output logic                     we_a_o,
   output logic [ADDR_WIDTH-1:0]    waddr_b_o,
   output logic [DATA_WIDTH-1:0]    wdata_b_o,
   output logic                     we_b_o,
   input  logic                     alloc_i,
   input  logic [ADDR_WIDTH-1:0]    alloc_addr_i,
   output logic [2**ADDR_WIDTH-1:0] busy_o,
   input  logic [ADDR_WIDTH-1:0]    fwd_raddr_i,
   output logic                     fwd_hit_o,
   output logic [DATA_WIDTH-1:0]    fwd_data_o
);

   localparam int   NREG       = 2**ADDR_WIDTH;
   localparam logic FP_DISCARD = (FPU == 0) || (ZFINX == 1);

   // source index: 0 = LSU, 1 = APU, 2 = EX
   logic [ADDR_WIDTH-1:0] w_addr [3];
   logic [DATA_WIDTH-1:0] w_data [3];
   logic [2:0]            w_vld;
   logic [2:0]            w_disc;
   logic [2:0]            w_gnt;
   logic [1:0]            w_ord [3];
   logic                  w_conf;
   logic                  w_sel_a_v, w_sel_b_v;
   logic [1:0]            w_sel_a, w_sel_b;
   logic [NREG-1:0]       w_busy_nxt;
   logic                  w_hit_a, w_hit_b;

   logic [1:0]            r_starv;
   logic                  r_we_a, r_we_b;
   logic [ADDR_WIDTH-1:0] r_waddr_a, r_waddr_b;
   logic [DATA_WIDTH-1:0] r_wdata_a, r_wdata_b;
   logic [NREG-1:0]       r_busy;

   assign w_vld     = {ex_valid_i, apu_valid_i, lsu_valid_i};
   assign w_addr[0] = lsu_addr_i;
   assign w_addr[1] = apu_addr_i;
   assign w_addr[2] = ex_addr_i;
   assign w_data[0] = lsu_data_i;
   assign w_data[1] = apu_data_i;
   assign w_data[2] = ex_data_i;

   // Discarded results (x0, or FP bank without a separate FP register file) need no port.
   always_comb begin
      w_disc = '0;
      for (int i = 0; i < 3; i++)
         w_disc[i] = (w_addr[i] == '0) || (FP_DISCARD && w_addr[i][ADDR_WIDTH-1]);
   end

   always_comb begin
      if (r_starv == 2'd3) begin
         w_ord[0] = 2'd2;
         w_ord[1] = 2'd0;
         w_ord[2] = 2'd1;
      end else begin
         w_ord[0] = 2'd0;
         w_ord[1] = 2'd1;
         w_ord[2] = 2'd2;
      end
   end

   always_comb begin
      w_gnt     = '0;
      w_conf    = 1'b0;
      w_sel_a_v = 1'b0;
      w_sel_b_v = 1'b0;
      w_sel_a   = '0;
      w_sel_b   = '0;
      for (int k = 0; k < 3; k++) begin
         w_conf = 1'b0;
         for (int j = 0; j < k; j++)
            if (w_vld[w_ord[j]] && !w_disc[w_ord[j]] && !w_disc[w_ord[k]] &&
                (w_addr[w_ord[j]] == w_addr[w_ord[k]]))
               w_conf = 1'b1;
         if (rst_n && w_vld[w_ord[k]] && !w_conf) begin
            if (w_disc[w_ord[k]]) begin
               w_gnt[w_ord[k]] = 1'b1;
            end else if (!w_sel_b_v) begin
               w_gnt[w_ord[k]] = 1'b1;
               w_sel_b_v       = 1'b1;
               w_sel_b         = w_ord[k];
            end else if (!w_sel_a_v) begin
               w_gnt[w_ord[k]] = 1'b1;
               w_sel_a_v       = 1'b1;
               w_sel_a         = w_ord[k];
            end
         end
      end
   end

   // Alloc is applied after the clears so a same-cycle re-allocation keeps the bit set.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_we_a) w_busy_nxt[r_waddr_a] = 1'b0;
      if (r_we_b) w_busy_nxt[r_waddr_b] = 1'b0;
      if (alloc_i && (alloc_addr_i != '0)) w_busy_nxt[alloc_addr_i] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_we_a    <= 1'b0;
         r_we_b    <= 1'b0;
         r_waddr_a <= '0;
         r_waddr_b <= '0;
         r_wdata_a <= '0;
         r_wdata_b <= '0;
         r_busy    <= '0;
         r_starv   <= '0;
      end else begin
         r_we_a <= w_sel_a_v;
         r_we_b <= w_sel_b_v;
         if (w_sel_a_v) begin
            r_waddr_a <= w_addr[w_sel_a];
            r_wdata_a <= w_data[w_sel_a];
         end
         if (w_sel_b_v) begin
            r_waddr_b <= w_addr[w_sel_b];
            r_wdata_b <= w_data[w_sel_b];
         end
         r_busy <= w_busy_nxt;
         if (!ex_valid_i || w_gnt[2])
            r_starv <= '0;
         else if (r_starv != 2'd3)
            r_starv <= r_starv + 2'd1;
      end
   end

   assign w_hit_b = r_we_b && (fwd_raddr_i != '0) && (r_waddr_b == fwd_raddr_i);
   assign w_hit_a = r_we_a && (fwd_raddr_i != '0) && (r_waddr_a == fwd_raddr_i);

   assign fwd_hit_o   = w_hit_a || w_hit_b;
   assign fwd_data_o  = w_hit_b ? r_wdata_b : (w_hit_a ? r_wdata_a : '0);
   assign lsu_ready_o = w_gnt[0];
   assign apu_ready_o = w_gnt[1];
   assign ex_ready_o  = w_gnt[2];
   assign we_a_o      = r_we_a;
   assign we_b_o      = r_we_b;
   assign waddr_a_o   = r_waddr_a;
   assign waddr_b_o   = r_waddr_b;
   assign wdata_a_o   = r_wdata_a;
   assign wdata_b_o   = r_wdata_b;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_cv32e40p_rf_wb_ctrl.sv
// Directed bench for cv32e40p_rf_wb_ctrl: inputs driven 1 ns after posedge, outputs checked mid-cycle.
module tb_cv32e40p_rf_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid_i, lsu_valid_i, apu_valid_i;
   logic [5:0]  ex_addr_i, lsu_addr_i, apu_addr_i;
   logic [31:0] ex_data_i, lsu_data_i, apu_data_i;
   logic        ex_ready_o, lsu_ready_o, apu_ready_o;
   logic [5:0]  waddr_a_o, waddr_b_o;
   logic [31:0] wdata_a_o, wdata_b_o;
   logic        we_a_o, we_b_o;
   logic        alloc_i;
   logic [5:0]  alloc_addr_i;
   logic [63:0] busy_o;
   logic [5:0]  fwd_raddr_i;
   logic        fwd_hit_o;
   logic [31:0] fwd_data_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cv32e40p_rf_wb_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid_i(ex_valid_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i), .ex_ready_o(ex_ready_o),
      .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
      .apu_valid_i(apu_valid_i), .apu_addr_i(apu_addr_i), .apu_data_i(apu_data_i), .apu_ready_o(apu_ready_o),
      .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
      .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
      .alloc_i(alloc_i), .alloc_addr_i(alloc_addr_i), .busy_o(busy_o),
      .fwd_raddr_i(fwd_raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle();
      ex_valid_i = 0; ex_addr_i = '0; ex_data_i = '0;
      lsu_valid_i = 0; lsu_addr_i = '0; lsu_data_i = '0;
      apu_valid_i = 0; apu_addr_i = '0; apu_data_i = '0;
      alloc_i = 0; alloc_addr_i = '0; fwd_raddr_i = '0;
   endtask

   initial begin
      // reset with results presented
      rst_n = 0;
      idle();
      ex_valid_i = 1; ex_addr_i = 6'd3; ex_data_i = 32'h33;
      lsu_valid_i = 1; lsu_addr_i = 6'd4;
      tick(); tick(); settle();
      chk("rst_ex_ready", ex_ready_o, 0);
      chk("rst_lsu_ready", lsu_ready_o, 0);
      chk("rst_we_a", we_a_o, 0);
      chk("rst_we_b", we_b_o, 0);
      chk("rst_waddr_b", waddr_b_o, 0);
      chk("rst_busy", busy_o, 0);

      // LSU + EX dual write
      tick(); rst_n = 1; idle();
      lsu_valid_i = 1; lsu_addr_i = 6'd5; lsu_data_i = 32'hAAAA_0000;
      ex_valid_i = 1; ex_addr_i = 6'd7; ex_data_i = 32'h1234;
      settle();
      chk("dual_lsu_ready", lsu_ready_o, 1);
      chk("dual_ex_ready", ex_ready_o, 1);
      chk("dual_apu_ready", apu_ready_o, 0);
      tick(); idle(); fwd_raddr_i = 6'd7; settle();
      chk("dual_we_b", we_b_o, 1);
      chk("dual_waddr_b", waddr_b_o, 5);
      chk("dual_wdata_b", wdata_b_o, 32'hAAAA_0000);
      chk("dual_we_a", we_a_o, 1);
      chk("dual_waddr_a", waddr_a_o, 7);
      chk("dual_wdata_a", wdata_a_o, 32'h1234);
      chk("fwd_a_hit", fwd_hit_o, 1);
      chk("fwd_a_data", fwd_data_o, 32'h1234);

      // three sources, EX starves for three cycles then wins port B
      tick(); idle();
      lsu_valid_i = 1; lsu_addr_i = 6'd1; lsu_data_i = 32'h11;
      apu_valid_i = 1; apu_addr_i = 6'd2; apu_data_i = 32'h22;
      ex_valid_i  = 1; ex_addr_i  = 6'd3; ex_data_i  = 32'h33;
      settle();
      chk("c1_lsu", lsu_ready_o, 1);
      chk("c1_apu", apu_ready_o, 1);
      chk("c1_ex", ex_ready_o, 0);
      tick(); settle();
      chk("c2_ex", ex_ready_o, 0);
      chk("c2_waddr_b", waddr_b_o, 1);
      chk("c2_waddr_a", waddr_a_o, 2);
      chk("c2_wdata_a", wdata_a_o, 32'h22);
      tick(); settle();
      chk("c3_ex", ex_ready_o, 0);
      tick(); settle();
      chk("c4_ex", ex_ready_o, 1);
      chk("c4_lsu", lsu_ready_o, 1);
      chk("c4_apu", apu_ready_o, 0);
      tick(); idle(); settle();
      chk("c4_waddr_b", waddr_b_o, 3);
      chk("c4_wdata_b", wdata_b_o, 32'h33);
      chk("c4_waddr_a", waddr_a_o, 1);

      // same-address conflict LSU vs APU
      tick(); idle();
      lsu_valid_i = 1; lsu_addr_i = 6'd9; lsu_data_i = 32'h9001;
      apu_valid_i = 1; apu_addr_i = 6'd9; apu_data_i = 32'h9002;
      settle();
      chk("conf_lsu", lsu_ready_o, 1);
      chk("conf_apu", apu_ready_o, 0);
      tick(); lsu_valid_i = 0; settle();
      chk("conf_apu2", apu_ready_o, 1);
      chk("conf1_wdata_b", wdata_b_o, 32'h9001);
      chk("conf1_we_a", we_a_o, 0);
      tick(); idle(); settle();
      chk("conf2_we_b", we_b_o, 1);
      chk("conf2_waddr_b", waddr_b_o, 9);
      chk("conf2_wdata_b", wdata_b_o, 32'h9002);

      // discarded destinations: x0 and FP bank
      tick(); ex_valid_i = 1; ex_addr_i = 6'd0; ex_data_i = 32'hFFFF_FFFF; settle();
      chk("x0_ready", ex_ready_o, 1);
      tick(); ex_addr_i = 6'd33; settle();
      chk("fp_ready", ex_ready_o, 1);
      chk("x0_we_a", we_a_o, 0);
      chk("x0_we_b", we_b_o, 0);
      tick(); idle(); settle();
      chk("fp_we_a", we_a_o, 0);
      chk("fp_we_b", we_b_o, 0);
      chk("fwd_x0_hit", fwd_hit_o, 0);

      // scoreboard + forwarding
      tick(); alloc_i = 1; alloc_addr_i = 6'd12; settle();
      chk("sb_busy_n", busy_o[12], 0);
      tick(); idle(); ex_valid_i = 1; ex_addr_i = 6'd12; ex_data_i = 32'h5555; settle();
      chk("sb_busy_n1", busy_o[12], 1);
      chk("sb_ex_ready", ex_ready_o, 1);
      tick(); idle(); fwd_raddr_i = 6'd12; settle();
      chk("sb_busy_n2", busy_o[12], 1);
      chk("sb_we_b", we_b_o, 1);
      chk("sb_fwd_hit", fwd_hit_o, 1);
      chk("sb_fwd_data", fwd_data_o, 32'h5555);
      tick(); settle();
      chk("sb_busy_n3", busy_o[12], 0);
      chk("sb_fwd_miss", fwd_hit_o, 0);
      chk("sb_fwd_zero", fwd_data_o, 0);

      // alloc wins over a same-cycle clear; alloc to x0 ignored
      tick(); idle(); alloc_i = 1; alloc_addr_i = 6'd20; settle();
      tick(); idle(); ex_valid_i = 1; ex_addr_i = 6'd20; ex_data_i = 32'h2020; settle();
      chk("aw_busy", busy_o[20], 1);
      tick(); idle(); alloc_i = 1; alloc_addr_i = 6'd20; settle();
      chk("aw_waddr_b", waddr_b_o, 20);
      tick(); idle(); alloc_i = 1; alloc_addr_i = 6'd0; settle();
      chk("aw_busy_kept", busy_o, 64'h1 << 20);
      tick(); idle(); settle();
      chk("aw_busy0", busy_o, 64'h1 << 20);

      // reset right after an accepted write
      tick(); idle(); ex_valid_i = 1; ex_addr_i = 6'd4; ex_data_i = 32'h77;
      alloc_i = 1; alloc_addr_i = 6'd6; settle();
      chk("rw_ex_ready", ex_ready_o, 1);
      tick(); idle(); rst_n = 0; lsu_valid_i = 1; lsu_addr_i = 6'd8; settle();
      chk("rw_pending_we", we_b_o, 1);
      chk("rw_lsu_ready", lsu_ready_o, 0);
      tick(); settle();
      chk("rw_we_b", we_b_o, 0);
      chk("rw_we_a", we_a_o, 0);
      chk("rw_busy", busy_o, 0);
      chk("rw_waddr_b", waddr_b_o, 0);
      chk("rw_wdata_b", wdata_b_o, 0);
      tick(); rst_n = 1; idle(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
